// File: rtl/cache_refill_unit_pkg.sv
// cache_refill_unit_pkg: shared refill geometry, FSM encoding and address-field helpers
package cache_refill_unit_pkg;
  localparam int CRU_ADDR_WIDTH = 32;
  localparam int CRU_WORD_WIDTH = 32;
  localparam int CRU_LINE_WORDS = 8;
  localparam int CRU_INDEX_WIDTH = 3;
  localparam int CRU_OFFSET_WIDTH = 5;
  localparam int CRU_TAG_WIDTH = CRU_ADDR_WIDTH - CRU_INDEX_WIDTH - CRU_OFFSET_WIDTH;
  localparam int CRU_CNT_WIDTH = $clog2(CRU_LINE_WORDS);
  typedef enum logic [2:0] {IDLE, REQ, RECV, WRITE, DONE} state_t;
  function automatic logic [CRU_TAG_WIDTH-1:0] addr_tag(input logic [CRU_ADDR_WIDTH-1:0] a);
    return a[CRU_ADDR_WIDTH-1 -: CRU_TAG_WIDTH];
  endfunction
  function automatic logic [CRU_INDEX_WIDTH-1:0] addr_index(input logic [CRU_ADDR_WIDTH-1:0] a);
    return a[CRU_OFFSET_WIDTH +: CRU_INDEX_WIDTH];
  endfunction
  function automatic logic [CRU_CNT_WIDTH-1:0] addr_word(input logic [CRU_ADDR_WIDTH-1:0] a);
    return a[CRU_OFFSET_WIDTH-1 -: CRU_CNT_WIDTH];
  endfunction
endpackage

// File: rtl/cache_refill_unit_line_assembly_buffer.sv
// line_assembly_buffer: beat counter, per-slot line storage and requested-word select
module line_assembly_buffer #(
  parameter int WORD_WIDTH = 32,
  parameter int LINE_WORDS = 8,
  parameter int CW = $clog2(LINE_WORDS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clr,
  input  logic                             wr,
  input  logic [WORD_WIDTH-1:0]            wdata,
  input  logic [CW-1:0]                    sel,
  output logic [LINE_WORDS*WORD_WIDTH-1:0] line,
  output logic [WORD_WIDTH-1:0]            word,
  output logic                             last
);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      line <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (wr) begin
      cnt <= cnt + CW'(1);
      line[cnt*WORD_WIDTH +: WORD_WIDTH] <= wdata;
    end
  assign last = cnt == CW'(LINE_WORDS - 1);
  assign word = line[sel*WORD_WIDTH +: WORD_WIDTH];
endmodule

// File: rtl/cache_refill_unit.sv
// cache_refill_unit: burst-reads a missing line, assembles it and writes data and tag arrays
module cache_refill_unit
  import cache_refill_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = CRU_ADDR_WIDTH,
  parameter int WORD_WIDTH = CRU_WORD_WIDTH,
  parameter int LINE_WORDS = CRU_LINE_WORDS,
  parameter int INDEX_WIDTH = CRU_INDEX_WIDTH,
  parameter int OFFSET_WIDTH = CRU_OFFSET_WIDTH,
  parameter int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             miss_valid,
  output logic                             miss_ready,
  input  logic [ADDR_WIDTH-1:0]            miss_addr,
  output logic                             mem_rd_req_valid,
  input  logic                             mem_rd_req_ready,
  output logic [ADDR_WIDTH-1:0]            mem_rd_addr,
  output logic [7:0]                       mem_rd_len,
  input  logic                             mem_rd_rdata_valid,
  output logic                             mem_rd_rdata_ready,
  input  logic [WORD_WIDTH-1:0]            mem_rd_rdata,
  input  logic                             mem_rd_last,
  output logic                             darray_wen,
  output logic [INDEX_WIDTH-1:0]           darray_waddr,
  output logic [LINE_WORDS*WORD_WIDTH-1:0] darray_wdata,
  output logic                             tag_wen,
  output logic [TAG_WIDTH:0]               tag_wdata,
  output logic                             refill_done,
  output logic [WORD_WIDTH-1:0]            refill_word,
  output logic                             refill_err
);
  localparam int CW = $clog2(LINE_WORDS);
  state_t state, nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic err_q, accept, beat, last_beat, unused_ok;
  assign accept = state == IDLE && miss_valid;
  assign beat = state == RECV && mem_rd_rdata_valid;
  assign unused_ok = ^addr_q[OFFSET_WIDTH-CW-1:0];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      addr_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) addr_q <= miss_addr;
      if (accept) err_q <= 1'b0;
      else if (beat && mem_rd_last != last_beat) err_q <= 1'b1;
    end
  always_comb begin
    nxt = state == IDLE  ? (miss_valid ? REQ : IDLE) :
          state == REQ   ? (mem_rd_req_ready ? RECV : REQ) :
          state == RECV  ? (beat && last_beat ? WRITE : RECV) :
          state == WRITE ? DONE : IDLE;
    miss_ready = state == IDLE;
    mem_rd_req_valid = state == REQ;
    mem_rd_rdata_ready = state == RECV;
    darray_wen = state == WRITE;
    tag_wen = state == WRITE;
    refill_done = state == DONE;
    refill_err = state == DONE && err_q;
    tag_wdata = tag_wen ? {1'b1, addr_q[ADDR_WIDTH-1 -: TAG_WIDTH]} : '0;
  end
  assign mem_rd_addr = {addr_q[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
  assign mem_rd_len = 8'(LINE_WORDS - 1);
  assign darray_waddr = addr_q[OFFSET_WIDTH +: INDEX_WIDTH];
  line_assembly_buffer #(.WORD_WIDTH(WORD_WIDTH), .LINE_WORDS(LINE_WORDS)) u_buf (
    .clk(clk),
    .rst(rst),
    .clr(accept),
    .wr(beat),
    .wdata(mem_rd_rdata),
    .sel(addr_q[OFFSET_WIDTH-1 -: CW]),
    .line(darray_wdata),
    .word(refill_word),
    .last(last_beat)
  );
endmodule

// File: tb/tb_cache_refill_unit.sv
// tb_cache_refill_unit: directed refills with a scoreboard of expected lines and words
module tb_cache_refill_unit;
  logic clk = 0, rst = 1;
  logic miss_valid = 0, miss_ready;
  logic [31:0] miss_addr = 0;
  logic mem_rd_req_valid, mem_rd_req_ready = 0;
  logic [31:0] mem_rd_addr;
  logic [7:0] mem_rd_len;
  logic mem_rd_rdata_valid = 0, mem_rd_rdata_ready, mem_rd_last = 0;
  logic [31:0] mem_rd_rdata = 0;
  logic darray_wen, tag_wen, refill_done, refill_err;
  logic [2:0] darray_waddr;
  logic [255:0] darray_wdata;
  logic [24:0] tag_wdata;
  logic [31:0] refill_word;
  typedef struct packed {
    logic [31:0]  raddr;
    logic [2:0]   idx;
    logic [24:0]  tag;
    logic [31:0]  word;
    logic         err;
    logic [255:0] line;
  } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  cache_refill_unit dut (
    .clk(clk), .rst(rst), .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .mem_rd_req_valid(mem_rd_req_valid), .mem_rd_req_ready(mem_rd_req_ready), .mem_rd_addr(mem_rd_addr),
    .mem_rd_len(mem_rd_len), .mem_rd_rdata_valid(mem_rd_rdata_valid), .mem_rd_rdata_ready(mem_rd_rdata_ready),
    .mem_rd_rdata(mem_rd_rdata), .mem_rd_last(mem_rd_last), .darray_wen(darray_wen), .darray_waddr(darray_waddr),
    .darray_wdata(darray_wdata), .tag_wen(tag_wen), .tag_wdata(tag_wdata), .refill_done(refill_done),
    .refill_word(refill_word), .refill_err(refill_err)
  );
  task automatic chk(input string tag, input logic [255:0] o, input logic [255:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic chk_quiet(input string tag);
    chk({tag, "_ctl"}, {miss_ready, mem_rd_req_valid, mem_rd_rdata_ready, darray_wen, tag_wen, refill_done, refill_err}, 7'b1000000);
    chk({tag, "_addr"}, {mem_rd_addr, darray_waddr, tag_wdata, refill_word}, 0);
    chk({tag, "_wdata"}, darray_wdata, 0);
  endtask
  task automatic refill(input logic [31:0] a, input logic [31:0] base, input int req_dly, input bit stall,
                        input int last_at, input int rst_at, input bit hold, input int exp_lat);
    exp_t e, x;
    int t, k, rw, wen_n, mr_n;
    bit tog, fin;
    e.raddr = {a[31:5], 5'b0};
    e.idx = a[7:5];
    e.tag = {1'b1, a[31:8]};
    e.word = base + 32'(a[4:2]);
    e.err = last_at != 7;
    for (int i = 0; i < 8; i++) e.line[i*32 +: 32] = base + 32'(i);
    sb.push_back(e);
    @(negedge clk);
    miss_valid = 1;
    miss_addr = a;
    chk("miss_ready_idle", miss_ready, 1);
    t = 0; k = 0; rw = 0; wen_n = 0; mr_n = 0; tog = 0; fin = 0;
    while (!fin && t < 200) begin
      @(negedge clk);
      t++;
      if (!hold) miss_valid = 0;
      if (miss_ready) mr_n++;
      mem_rd_req_ready = mem_rd_req_valid && rw >= req_dly;
      if (mem_rd_req_valid) begin
        if (rw == 0) chk("mem_rd_addr", mem_rd_addr, e.raddr);
        if (rw == 0) chk("mem_rd_len", mem_rd_len, 7);
        rw++;
      end
      if (mem_rd_rdata_ready && k == rst_at) begin
        rst = 1;
        mem_rd_rdata_valid = 1;
        mem_rd_rdata = base + 32'(k);
        #1 chk_quiet("mid_burst_reset");
        @(negedge clk);
        rst = 0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          chk("post_reset_idle", {darray_wen, refill_done, mem_rd_req_valid, mem_rd_rdata_ready, miss_ready}, 5'b00001);
        end
        mem_rd_rdata_valid = 0;
        void'(sb.pop_back());
        fin = 1;
      end else if (mem_rd_rdata_ready) begin
        tog = ~tog;
        mem_rd_rdata_valid = stall ? tog : 1'b1;
        mem_rd_rdata = base + 32'(k);
        mem_rd_last = k == last_at;
        if (mem_rd_rdata_valid) k++;
      end else begin
        mem_rd_rdata_valid = 0;
        mem_rd_last = 0;
      end
      if (!fin && darray_wen) begin
        wen_n++;
        chk("darray_wdata", darray_wdata, sb[0].line);
        chk("darray_waddr", darray_waddr, sb[0].idx);
        chk("tag_wdata", tag_wdata, sb[0].tag);
      end
      if (!fin && refill_done) begin
        x = sb.pop_front();
        chk("refill_word", refill_word, x.word);
        chk("refill_err", refill_err, x.err);
        chk("beats_sent", k, 8);
        chk("wen_cycles", wen_n, 1);
        chk("miss_ready_busy", mr_n, 0);
        chk("wdata_in_done", darray_wdata, x.line);
        if (exp_lat >= 0) chk("latency", t, exp_lat);
        fin = 1;
      end
    end
    if (!fin) chk("timeout", 0, 1);
  endtask
  initial begin
    #1 chk_quiet("reset_held");
    @(negedge clk);
    rst = 0;
    #1 chk_quiet("reset_released");
    refill(32'h0000_1234, 32'h100, 0, 0, 7, -1, 0, 11);
    refill(32'h0000_1234, 32'h100, 3, 1, 7, -1, 0, -1);
    refill(32'hABCD_E0E8, 32'h200, 0, 0, 5, -1, 0, 11);
    refill(32'h0000_0040, 32'h300, 1, 0, 7, 4, 0, -1);
    refill(32'h1357_9BDC, 32'h400, 0, 1, 7, -1, 0, -1);
    refill(32'h0000_2464, 32'h500, 0, 0, 7, -1, 1, 11);
    refill(32'hFFFF_FFFC, 32'h600, 2, 0, 7, -1, 0, 13);
    miss_valid = 0;
    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_refill_unit.md
# cache_refill_unit

Line-refill engine sitting directly upstream of the cache data array. On a miss it issues one burst read to memory, assembles eight 32-bit beats into a 256-bit line, then performs a single-cycle write into the data array and tag array. It reports completion to the cache controller together with the originally requested word.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width
- WORD_WIDTH, 32, memory beat width
- LINE_WORDS, 8, beats per line (power of two)
- INDEX_WIDTH, 3, set index width (matches data array address width)
- OFFSET_WIDTH, 5, byte offset within line, log2(LINE_WORDS*WORD_WIDTH/8)
- TAG_WIDTH, 24, ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH

Ports:
- clk  in  1  single clock; everything is rising-edge
- rst  in  1  asynchronous, active-high reset
- miss_valid  in  1  controller requests a refill
- miss_ready  out  1  high only in IDLE
- miss_addr  in  ADDR_WIDTH  byte address that missed
- mem_rd_req_valid  out  1  burst read request
- mem_rd_req_ready  in  1  memory accepts request
- mem_rd_addr  out  ADDR_WIDTH  line-aligned address (offset bits zero)
- mem_rd_len  out  8  constant LINE_WORDS-1
- mem_rd_rdata_valid  in  1  beat valid
- mem_rd_rdata_ready  out  1  high only in RECV
- mem_rd_rdata  in  WORD_WIDTH  beat data
- mem_rd_last  in  1  final beat marker from memory
- darray_wen  out  1  data array write enable
- darray_waddr  out  INDEX_WIDTH  set index
- darray_wdata  out  LINE_WORDS*WORD_WIDTH  assembled line
- tag_wen  out  1  tag array write enable
- tag_wdata  out  TAG_WIDTH+1  {valid=1, tag}
- refill_done  out  1  one-cycle completion pulse
- refill_word  out  WORD_WIDTH  word at miss offset, valid with refill_done
- refill_err  out  1  last-marker mismatch, valid with refill_done

## Operation
- States: IDLE, REQ, RECV, WRITE, DONE.
- IDLE: miss_ready=1; on miss_valid latch miss_addr, clear beat counter and err flag, go REQ.
- REQ: mem_rd_req_valid=1, mem_rd_addr={tag,index,OFFSET_WIDTH'b0}; hold until mem_rd_req_ready, then RECV.
- RECV: mem_rd_rdata_ready=1; each accepted beat stored in buffer slot beat_cnt (slot k at bits [k*WORD_WIDTH +: WORD_WIDTH]), counter increments. Transition to WRITE after the LINE_WORDS-th beat.
- Beat count is authoritative; mem_rd_last only checked: err set if last is high on beat < LINE_WORDS-1 or low on the final beat. Line still completes after exactly LINE_WORDS beats.
- WRITE: darray_wen=1 and tag_wen=1 for exactly one cycle; darray_waddr = latched index; darray_wdata = buffer. Go DONE.
- DONE: refill_done=1 one cycle; refill_word = buffer slot miss_addr[OFFSET_WIDTH-1:2]; refill_err = err flag. Go IDLE.
- Miss requests outside IDLE are not accepted (miss_ready=0); controller holds miss_valid.

## Timing
- Reset (any state, mid-burst included): state IDLE, counter 0, err 0; all valid/enable/done outputs 0, miss_ready 1 after reset release; data/address outputs 0. Beats still arriving after reset are not consumed (ready=0).
- Minimum latency miss accept to refill_done: 1 (REQ) + LINE_WORDS beats + 1 (WRITE) + 1 (DONE) cycles with zero memory stalls = 11 cycles.
- Valid/ready transfer occurs on a rising edge where both are high; outputs are registered-state decoded, no combinational path from mem_rd_req_ready or mem_rd_rdata_valid to any valid output.
- Counter is log2(LINE_WORDS) bits and wraps to 0 on the final beat.
- darray_wdata stable from WRITE through DONE; buffer not cleared between refills.

## Structure
- Shared package: state encoding constants, LINE_WORDS, WORD_WIDTH, INDEX/OFFSET/TAG widths and address-field slicing helpers, shared with the data and tag arrays.
- One sub-module natural: line_assembly_buffer (beat counter + slot write + word select), leaving the FSM and handshakes in the top.

## Test plan
- miss_addr 0x0000_1234, memory returns beats 0x100..0x107 no stalls -> mem_rd_addr 0x0000_1220, darray_waddr 1, slot k = 0x100+k, tag_wdata {1,0x000012}, refill_word 0x105, done at cycle 11, err 0.
- Same with req_ready delayed 3 cycles and rdata_valid toggling every other cycle -> identical line, no lost/duplicated beats, wen exactly one cycle.
- mem_rd_last asserted on beat 5 -> line still completes after 8 beats, refill_err 1 with refill_done.
- rst pulsed during beat 4 -> all outputs 0 immediately, no darray_wen; next miss refills cleanly.
- Back-to-back misses with miss_valid held high -> second accepted only the cycle after refill_done; miss_ready 0 throughout first refill.
